// File: rtl/pmu_counter_bank_if.sv
// Level-held four-phase read/write request channel between the PMU front end
// (master) and the counter bank (slave).
interface pmu_counter_bank_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 64
);
  logic                  counter_read_enable;
  logic [ADDR_WIDTH-1:0] counter_read_address;
  logic                  counter_read_valid;
  logic [CNT_WIDTH-1:0]  counter_read_data;
  logic                  counter_write_enable;
  logic [ADDR_WIDTH-1:0] counter_write_address;
  logic [CNT_WIDTH-1:0]  counter_write_data;
  logic                  counter_write_valid;

  modport master (
    output counter_read_enable, counter_read_address,
    output counter_write_enable, counter_write_address, counter_write_data,
    input  counter_read_valid, counter_read_data, counter_write_valid
  );

  modport slave (
    input  counter_read_enable, counter_read_address,
    input  counter_write_enable, counter_write_address, counter_write_data,
    output counter_read_valid, counter_read_data, counter_write_valid
  );
endinterface

// File: rtl/pmu_counter_bank.sv
// PMU event counter bank: CTRL, W1C overflow status and N_COUNTERS wrapping counters.
// Define PMU_OVERFLOW_IRQ_EN to add CTRL bit2 and the registered overflow_irq_o output.
module pmu_counter_bank #(
  parameter int N_COUNTERS = 23,
  parameter int CNT_WIDTH  = 64,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_COUNTERS-1:0] events_i,
  pmu_counter_bank_if.slave     bus
`ifdef PMU_OVERFLOW_IRQ_EN
  ,
  output logic                  overflow_irq_o
`endif
);

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_ACK  = 1'b1;
  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_ACK  = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_OVF  = ADDR_WIDTH'(1);

  logic [0:0]            r_rd_state;
  logic [0:0]            r_wr_state;
  logic [CNT_WIDTH-1:0]  r_rd_data;
  logic [CNT_WIDTH-1:0]  r_cnt [N_COUNTERS];
  logic                  r_ctrl_en;
  logic [N_COUNTERS-1:0] r_ovf;

  logic [CNT_WIDTH-1:0]  w_ctrl_rd;
  logic [CNT_WIDTH-1:0]  w_rd_data;
  logic                  w_wr_fire;
  logic                  w_ctrl_wr;
  logic                  w_ovf_wr;
  logic                  w_clear_all;
  logic [N_COUNTERS-1:0] w_ovf_clr;
  logic [N_COUNTERS-1:0] w_cnt_wr;
  logic [N_COUNTERS-1:0] w_inc;
  logic [N_COUNTERS-1:0] w_wrap;

`ifdef PMU_OVERFLOW_IRQ_EN
  logic r_ctrl_irq_en;
  logic r_irq;
  assign w_ctrl_rd      = CNT_WIDTH'({r_ctrl_irq_en, 1'b0, r_ctrl_en});
  assign overflow_irq_o = r_irq;
`else
  assign w_ctrl_rd = CNT_WIDTH'(r_ctrl_en);
`endif

  // A write takes effect only on the edge that moves the write FSM out of idle.
  assign w_wr_fire   = (r_wr_state == W_IDLE) && bus.counter_write_enable;
  assign w_ctrl_wr   = w_wr_fire && (bus.counter_write_address == A_CTRL);
  assign w_ovf_wr    = w_wr_fire && (bus.counter_write_address == A_OVF);
  assign w_clear_all = w_ctrl_wr && bus.counter_write_data[1];
  assign w_ovf_clr   = w_ovf_wr ? N_COUNTERS'(bus.counter_write_data) : '0;

  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned (no latch).
    w_rd_data = '0;
    if (bus.counter_read_address == A_CTRL)
      w_rd_data = w_ctrl_rd;
    else if (bus.counter_read_address == A_OVF)
      w_rd_data = CNT_WIDTH'(r_ovf);
    for (int i = 0; i < N_COUNTERS; i++)
      if (32'(bus.counter_read_address) == 32'(i + 2))
        w_rd_data = r_cnt[i];
  end

  always_comb begin
    w_cnt_wr = '0;
    w_inc    = '0;
    w_wrap   = '0;
    for (int i = 0; i < N_COUNTERS; i++) begin
      w_cnt_wr[i] = w_wr_fire && (32'(bus.counter_write_address) == 32'(i + 2));
      w_inc[i]    = r_ctrl_en && events_i[i];
      w_wrap[i]   = w_inc[i] && !w_cnt_wr[i] && !w_clear_all && (r_cnt[i] == '1);
    end
  end

  // Priority per counter: clear-all, then write, then increment.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking (<=) so all registers update together.
    // NOTE: the counters are software-visible, so each entry is reset explicitly.
    for (int i = 0; i < N_COUNTERS; i++) begin
      if (rst_i || w_clear_all)
        r_cnt[i] <= '0;
      else if (w_cnt_wr[i])
        r_cnt[i] <= bus.counter_write_data;
      else if (w_inc[i])
        r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ctrl_en <= 1'b0;
      r_ovf     <= '0;
`ifdef PMU_OVERFLOW_IRQ_EN
      r_ctrl_irq_en <= 1'b0;
      r_irq         <= 1'b0;
`endif
    end else begin
      if (w_ctrl_wr) begin
        r_ctrl_en <= bus.counter_write_data[0];
`ifdef PMU_OVERFLOW_IRQ_EN
        r_ctrl_irq_en <= bus.counter_write_data[2];
`endif
      end
      // A wrap on the same edge wins over the W1C of that bit.
      r_ovf <= (r_ovf & ~w_ovf_clr) | w_wrap;
`ifdef PMU_OVERFLOW_IRQ_EN
      r_irq <= r_ctrl_irq_en && (|r_ovf);
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_state <= R_IDLE;
      r_rd_data  <= '0;
    end else if (r_rd_state == R_IDLE) begin
      if (bus.counter_read_enable) begin
        r_rd_state <= R_ACK;
        r_rd_data  <= w_rd_data;
      end
    end else if (!bus.counter_read_enable) begin
      r_rd_state <= R_IDLE;
      r_rd_data  <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_wr_state <= W_IDLE;
    else if (r_wr_state == W_IDLE)
      r_wr_state <= bus.counter_write_enable ? W_ACK : W_IDLE;
    else if (!bus.counter_write_enable)
      r_wr_state <= W_IDLE;
  end

  assign bus.counter_read_valid  = (r_rd_state == R_ACK);
  assign bus.counter_read_data   = r_rd_data;
  assign bus.counter_write_valid = (r_wr_state == W_ACK);

endmodule
